// File: rtl/axi_id_alloc_table_if.sv
// Push/pop handshake bundle for the AXI ID allocation table.
// The slave modport is the table's view; the master modport is the ID modifier's view.
interface axi_id_alloc_table_if #(
    parameter int unsigned SlvIdWidth = 4,
    parameter int unsigned MstIdWidth = 2
);
    logic                  push_valid_i;
    logic [SlvIdWidth-1:0] push_slv_id_i;
    logic                  push_ready_o;
    logic [MstIdWidth-1:0] push_mst_id_o;
    logic                  pop_i;
    logic [MstIdWidth-1:0] pop_mst_id_i;
    logic [SlvIdWidth-1:0] pop_slv_id_o;
    logic                  full_o;
    logic                  empty_o;
    logic                  err_o;

    modport master (
        output push_valid_i, push_slv_id_i, pop_i, pop_mst_id_i,
        input  push_ready_o, push_mst_id_o, pop_slv_id_o, full_o, empty_o, err_o
    );

    modport slave (
        input  push_valid_i, push_slv_id_i, pop_i, pop_mst_id_i,
        output push_ready_o, push_mst_id_o, pop_slv_id_o, full_o, empty_o, err_o
    );
endinterface

// File: rtl/axi_id_alloc_table.sv
// Remaps wide slave-side AXI IDs onto a small table of master-side IDs, counting
// outstanding transactions per entry and restoring the original ID on responses.
module axi_id_alloc_table #(
    parameter int unsigned SlvIdWidth   = 4,
    parameter int unsigned MstIdWidth   = 2,
    parameter int unsigned MaxTxnsPerId = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    axi_id_alloc_table_if.slave   bus
);
    localparam int unsigned NumEntries = 2 ** MstIdWidth;
    localparam int unsigned CntWidth   = $clog2(MaxTxnsPerId + 1);
    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxTxnsPerId);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t                state_q;
    logic [MstIdWidth-1:0] hold_idx_q;
    logic [SlvIdWidth-1:0] slv_id_q [NumEntries];
    logic [CntWidth-1:0]   cnt_q    [NumEntries];
    logic                  err_q;

    logic [NumEntries-1:0] valid_vec;
    logic                  match_found;
    logic                  free_found;
    logic [MstIdWidth-1:0] match_idx;
    logic [MstIdWidth-1:0] free_idx;
    logic [MstIdWidth-1:0] sel_idx;
    logic                  sel_valid;
    logic                  ready;
    logic                  fire;
    logic [MstIdWidth-1:0] pop_idx;
    logic                  pop_ok;
    logic [NumEntries-1:0] inc_vec;
    logic [NumEntries-1:0] dec_vec;

    // Lookup: existing entry for this slave ID, and lowest free entry.
    always_comb begin
        valid_vec   = '0;
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int unsigned i = 0; i < NumEntries; i++) begin
            valid_vec[i] = (cnt_q[i] != '0);
            if (valid_vec[i] && (slv_id_q[i] == bus.push_slv_id_i) && !match_found) begin
                match_found = 1'b1;
                match_idx   = MstIdWidth'(i);
            end
            if (!valid_vec[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = MstIdWidth'(i);
            end
        end
    end

    // Selection uses only registered state and push inputs, so pop never reaches ready.
    always_comb begin
        sel_idx   = '0;
        sel_valid = 1'b0;
        ready     = 1'b0;
        if (state_q == HOLD) begin
            sel_idx   = hold_idx_q;
            sel_valid = 1'b1;
            if (cnt_q[hold_idx_q] == '0) begin
                ready = 1'b1;
            end else if (slv_id_q[hold_idx_q] == bus.push_slv_id_i) begin
                ready = (cnt_q[hold_idx_q] < MaxCnt);
            end
        end else if (match_found) begin
            sel_idx   = match_idx;
            sel_valid = 1'b1;
            ready     = (cnt_q[match_idx] < MaxCnt);
        end else if (free_found) begin
            sel_idx   = free_idx;
            sel_valid = 1'b1;
            ready     = 1'b1;
        end
    end

    assign fire    = bus.push_valid_i && ready;
    assign pop_idx = bus.pop_mst_id_i;
    assign pop_ok  = bus.pop_i && (cnt_q[pop_idx] != '0);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int unsigned i = 0; i < NumEntries; i++) begin
            inc_vec[i] = fire && (sel_idx == MstIdWidth'(i));
            dec_vec[i] = pop_ok && (pop_idx == MstIdWidth'(i));
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            hold_idx_q <= '0;
            err_q      <= 1'b0;
            for (int unsigned i = 0; i < NumEntries; i++) begin
                cnt_q[i]    <= '0;
                slv_id_q[i] <= '0;
            end
        end else begin
            err_q <= bus.pop_i && (cnt_q[pop_idx] == '0);
            // Simultaneous push and pop on one entry cancel out.
            for (int unsigned i = 0; i < NumEntries; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    cnt_q[i] <= cnt_q[i] + CntWidth'(1);
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    cnt_q[i] <= cnt_q[i] - CntWidth'(1);
                end
                if (inc_vec[i]) begin
                    slv_id_q[i] <= bus.push_slv_id_i;
                end
            end
            // HOLD pins the offered master ID across a stalled handshake.
            case (state_q)
                IDLE: begin
                    if (bus.push_valid_i && !ready && sel_valid) begin
                        state_q    <= HOLD;
                        hold_idx_q <= sel_idx;
                    end
                end
                HOLD: begin
                    if (fire || !bus.push_valid_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.push_ready_o  = ready;
    assign bus.push_mst_id_o = sel_idx;
    assign bus.pop_slv_id_o  = slv_id_q[pop_idx];
    assign bus.full_o        = &valid_vec;
    assign bus.empty_o       = ~|valid_vec;
    assign bus.err_o         = err_q;
endmodule

// File: tb/tb_axi_id_alloc_table.sv
// Scoreboard bench for axi_id_alloc_table: directed pushes/pops queue expectations,
// a negedge monitor checks accepted pushes, returned IDs and error pulses.
module tb_axi_id_alloc_table;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [1:0] exp_push_q [$];
    logic [3:0] exp_pop_q  [$];
    int         exp_err_q  [$];

    axi_id_alloc_table_if #(.SlvIdWidth(4), .MstIdWidth(2)) bus ();

    axi_id_alloc_table #(
        .SlvIdWidth  (4),
        .MstIdWidth  (2),
        .MaxTxnsPerId(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares DUT outputs against queued expectations.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.push_valid_i && bus.push_ready_o) begin
                if (exp_push_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL push_unexpected: got fire mst %0h expected none", bus.push_mst_id_o);
                end else begin
                    chk("push_mst_id", 32'(bus.push_mst_id_o), 32'(exp_push_q.pop_front()));
                end
            end
            if (bus.pop_i) begin
                if (exp_pop_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL pop_unexpected: got pop slv %0h expected none", bus.pop_slv_id_o);
                end else begin
                    chk("pop_slv_id", 32'(bus.pop_slv_id_o), 32'(exp_pop_q.pop_front()));
                end
            end
            if (bus.err_o) begin
                if (exp_err_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL err_unexpected: got err at cycle %0d expected none", cyc);
                end else begin
                    chk("err_cycle", 32'(cyc), 32'(exp_err_q.pop_front()));
                end
            end
        end
    end

    // Single push, waiting a bounded number of cycles for ready.
    task automatic push1(input logic [3:0] id, input logic [1:0] exp_mst);
        int n = 0;
        exp_push_q.push_back(exp_mst);
        bus.push_valid_i  = 1'b1;
        bus.push_slv_id_i = id;
        @(negedge clk);
        while (!bus.push_ready_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.push_ready_o) begin
            n_checks++; n_fail++;
            $display("FAIL push_timeout: got ready 0 expected 1 for id %0h", id);
        end
        tick();
        bus.push_valid_i = 1'b0;
    endtask

    task automatic pop1(input logic [1:0] idx, input logic [3:0] exp_slv, input bit legal);
        exp_pop_q.push_back(exp_slv);
        if (!legal) exp_err_q.push_back(cyc + 1);
        bus.pop_i        = 1'b1;
        bus.pop_mst_id_i = idx;
        tick();
        bus.pop_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.push_valid_i  = 1'b0;
        bus.push_slv_id_i = '0;
        bus.pop_i         = 1'b0;
        bus.pop_mst_id_i  = '0;
        repeat (2) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_empty", 32'(bus.empty_o), 1);
        chk("rst_full", 32'(bus.full_o), 0);
        chk("rst_mst_id", 32'(bus.push_mst_id_o), 0);
        chk("rst_pop_slv", 32'(bus.pop_slv_id_o), 0);
        chk("rst_err", 32'(bus.err_o), 0);
        chk("rst_ready", 32'(bus.push_ready_o), 1);
        tick();

        // Same ID reuses entry, new ID takes next free entry
        push1(4'h5, 2'd0);
        push1(4'h5, 2'd0);
        push1(4'h9, 2'd1);
        @(negedge clk);
        chk("t1_empty", 32'(bus.empty_o), 0);
        chk("t1_full", 32'(bus.full_o), 0);
        tick();
        pop1(2'd0, 4'h5, 1'b1);
        pop1(2'd0, 4'h5, 1'b1);
        pop1(2'd1, 4'h9, 1'b1);
        pop1(2'd0, 4'h5, 1'b0);
        @(negedge clk);
        chk("t1_empty_after", 32'(bus.empty_o), 1);
        tick();

        // Per-entry limit stalls the fifth push until a pop
        repeat (4) push1(4'h3, 2'd0);
        exp_push_q.push_back(2'd0);
        bus.push_valid_i  = 1'b1;
        bus.push_slv_id_i = 4'h3;
        repeat (2) begin
            @(negedge clk);
            chk("t2_stall_ready", 32'(bus.push_ready_o), 0);
            chk("t2_stall_mst", 32'(bus.push_mst_id_o), 0);
            tick();
        end
        exp_pop_q.push_back(4'h3);
        bus.pop_i        = 1'b1;
        bus.pop_mst_id_i = 2'd0;
        @(negedge clk);
        chk("t2_pop_no_ready", 32'(bus.push_ready_o), 0);
        tick();
        bus.pop_i = 1'b0;
        @(negedge clk);
        chk("t2_ready_after_pop", 32'(bus.push_ready_o), 1);
        tick();
        bus.push_valid_i = 1'b0;
        repeat (4) pop1(2'd0, 4'h3, 1'b1);

        // Full table: new ID waits for a freed entry
        push1(4'h1, 2'd0);
        push1(4'h2, 2'd1);
        push1(4'h4, 2'd2);
        push1(4'h8, 2'd3);
        @(negedge clk);
        chk("t3_full", 32'(bus.full_o), 1);
        chk("t3_empty", 32'(bus.empty_o), 0);
        tick();
        exp_push_q.push_back(2'd2);
        exp_pop_q.push_back(4'h4);
        bus.push_valid_i  = 1'b1;
        bus.push_slv_id_i = 4'hA;
        bus.pop_i         = 1'b1;
        bus.pop_mst_id_i  = 2'd2;
        @(negedge clk);
        chk("t3_noslot_ready", 32'(bus.push_ready_o), 0);
        chk("t3_noslot_mst", 32'(bus.push_mst_id_o), 0);
        tick();
        bus.pop_i = 1'b0;
        @(negedge clk);
        chk("t3_freed_full", 32'(bus.full_o), 0);
        chk("t3_freed_ready", 32'(bus.push_ready_o), 1);
        tick();
        bus.push_valid_i = 1'b0;
        @(negedge clk);
        chk("t3_refull", 32'(bus.full_o), 1);
        tick();
        pop1(2'd0, 4'h1, 1'b1);
        pop1(2'd1, 4'h2, 1'b1);
        pop1(2'd2, 4'hA, 1'b1);
        pop1(2'd3, 4'h8, 1'b1);

        // Stalled push keeps its master ID while a lower entry frees
        push1(4'h6, 2'd0);
        repeat (4) push1(4'h7, 2'd1);
        exp_push_q.push_back(2'd1);
        bus.push_valid_i  = 1'b1;
        bus.push_slv_id_i = 4'h7;
        repeat (3) begin
            @(negedge clk);
            chk("t4_hold_mst", 32'(bus.push_mst_id_o), 1);
            chk("t4_hold_ready", 32'(bus.push_ready_o), 0);
            tick();
        end
        exp_pop_q.push_back(4'h6);
        bus.pop_i        = 1'b1;
        bus.pop_mst_id_i = 2'd0;
        tick();
        bus.pop_i = 1'b0;
        @(negedge clk);
        chk("t4_after_free_mst", 32'(bus.push_mst_id_o), 1);
        chk("t4_after_free_ready", 32'(bus.push_ready_o), 0);
        exp_pop_q.push_back(4'h7);
        bus.pop_i        = 1'b1;
        bus.pop_mst_id_i = 2'd1;
        tick();
        bus.pop_i = 1'b0;
        @(negedge clk);
        chk("t4_release_ready", 32'(bus.push_ready_o), 1);
        tick();
        bus.push_valid_i = 1'b0;
        repeat (4) pop1(2'd1, 4'h7, 1'b1);

        // Same-cycle push and pop cancel; illegal pop flags error only
        push1(4'h5, 2'd0);
        exp_push_q.push_back(2'd0);
        exp_pop_q.push_back(4'h5);
        bus.push_valid_i  = 1'b1;
        bus.push_slv_id_i = 4'h5;
        bus.pop_i         = 1'b1;
        bus.pop_mst_id_i  = 2'd0;
        tick();
        bus.push_valid_i = 1'b0;
        bus.pop_i        = 1'b0;
        @(negedge clk);
        chk("t5_still_busy", 32'(bus.empty_o), 0);
        tick();
        pop1(2'd3, 4'h8, 1'b0);
        @(negedge clk);
        chk("t5_err_no_change_empty", 32'(bus.empty_o), 0);
        chk("t5_err_no_change_full", 32'(bus.full_o), 0);
        tick();
        pop1(2'd0, 4'h5, 1'b1);
        @(negedge clk);
        chk("t5_cnt_was_one", 32'(bus.empty_o), 1);
        tick();

        // Reset mid-operation discards outstanding entries
        push1(4'h1, 2'd0);
        push1(4'h2, 2'd1);
        push1(4'h3, 2'd2);
        @(negedge clk);
        chk("t6_busy", 32'(bus.empty_o), 0);
        tick();
        bus.pop_mst_id_i = 2'd0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_empty", 32'(bus.empty_o), 1);
        chk("t6_full", 32'(bus.full_o), 0);
        chk("t6_mst_id", 32'(bus.push_mst_id_o), 0);
        chk("t6_pop_slv", 32'(bus.pop_slv_id_o), 0);
        tick();
        pop1(2'd1, 4'h0, 1'b0);

        repeat (3) @(negedge clk);
        chk("q_push_left", 32'(exp_push_q.size()), 0);
        chk("q_pop_left", 32'(exp_pop_q.size()), 0);
        chk("q_err_left", 32'(exp_err_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
